id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register feeding the execute-stage units (SLL shifter, ALU, branch compare).

---
 rtl/id_ex_pipe_reg.sv | 100 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID->EX pipeline register with valid/ready handshake, stall, flush and bubble counter
// An empty or flushed slot holds all-zero payload, which the execute stage decodes as sll $0,$0,0.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        inst31_26,
  output logic [5:0]        inst5_0,
  output logic [4:0]        inst10_6,
  output logic [4:0]        rs_idx,
  output logic [4:0]        rt_idx,
  output logic [4:0]        rd_idx,
  output logic [DATA_W-1:0] dataa,
  output logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] imm_sext,
  output logic [DATA_W-1:0] pc_plus4_q,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_dataa;
  logic [DATA_W-1:0] r_datab;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_bubble;

  logic              w_load;
  logic              w_drain;
  logic              w_next_valid;
  logic [DATA_W-1:0] w_imm;

  assign in_ready     = !stall & !reset & (!r_valid | out_ready);
  assign w_load       = in_valid & in_ready & !flush;
  // Stall blocks the downstream transfer even when out_ready is high.
  assign w_drain      = r_valid & out_ready & !stall;
  assign w_next_valid = !flush & (w_load | (r_valid & !w_drain));
  assign w_imm        = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_dataa <= '0;
      r_datab <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
    end else if (flush || (w_drain && !w_load)) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_dataa <= '0;
      r_datab <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_instr <= instr;
      r_dataa <= rs_data;
      r_datab <= rt_data;
      r_imm   <= w_imm;
      r_pc    <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble <= '0;
    end else if (!w_next_valid && (r_bubble != {CNT_W{1'b1}})) begin
      r_bubble <= r_bubble + CNT_ONE;
    end
  end

  assign out_valid  = r_valid;
  assign inst31_26  = r_instr[31:26];
  assign rs_idx     = r_instr[25:21];
  assign rt_idx     = r_instr[20:16];
  assign rd_idx     = r_instr[15:11];
  assign inst10_6   = r_instr[10:6];
  assign inst5_0    = r_instr[5:0];
  assign dataa      = r_dataa;
  assign datab      = r_datab;
  assign imm_sext   = r_imm;
  assign pc_plus4_q = r_pc;
  assign bubble_cnt = r_bubble;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg with directed and random stimulus
module tb_id_ex_pipe_reg;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [31:0]   instr;
  logic [DW-1:0] pc_plus4, rs_data, rt_data;
  logic [5:0]    inst31_26, inst5_0;
  logic [4:0]    inst10_6, rs_idx, rt_idx, rd_idx;
  logic [DW-1:0] dataa, datab, imm_sext, pc_plus4_q;
  logic [CW-1:0] bubble_cnt;

  id_ex_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .inst31_26(inst31_26), .inst5_0(inst5_0), .inst10_6(inst10_6),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .dataa(dataa), .datab(datab), .imm_sext(imm_sext), .pc_plus4_q(pc_plus4_q),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   bub = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ins = ins;
    e.a   = a;
    e.b   = b;
    e.pc  = pc;
    e.imm = ins[15] ? (32'hFFFF_0000 + {16'h0, ins[15:0]}) : {16'h0, ins[15:0]};
    return e;
  endfunction

  // Reference model: a slot holding at most one instruction plus an idle-cycle tally.
  initial forever begin
    @(posedge reset);
    q.delete();
    bub = 0;
  end

  initial forever begin
    bit acc;
    @(posedge clk);
    if (!reset) begin
      acc = in_valid && !stall && (q.size() == 0 || out_ready) && !flush;
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready && !stall) void'(q.pop_front());
        if (acc) q.push_back(mk(instr, pc_plus4, rs_data, rt_data));
      end
      if (q.size() == 0 && bub < CMAX) bub++;
    end
  end

  // Monitor: compares presented contents against the scoreboard head every cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (q.size() != 0) e = q[0];
      else e = mk(32'h0, 32'h0, 32'h0, 32'h0);
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(!stall && (q.size() == 0 || out_ready)));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
      chk("instr_fields", 64'({inst31_26, rs_idx, rt_idx, rd_idx, inst10_6, inst5_0}), 64'(e.ins));
      chk("dataa", 64'(dataa), 64'(e.a));
      chk("datab", 64'(datab), 64'(e.b));
      chk("imm_sext", 64'(imm_sext), 64'(e.imm));
      chk("pc_plus4_q", 64'(pc_plus4_q), 64'(e.pc));
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic st,
                     input logic fl, input logic ordy);
    in_valid  = iv;
    instr     = ins;
    pc_plus4  = $urandom;
    rs_data   = $urandom;
    rt_data   = $urandom;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_ready", 64'(in_ready), 64'd0);
    chk("rst_async_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_async_payload", 64'({inst31_26, rs_idx, rt_idx, rd_idx, inst10_6, inst5_0}), 64'd0);
    chk("rst_async_data", {dataa, pc_plus4_q}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [31:0] a_pc, b_rs;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; instr = '0; pc_plus4 = '0; rs_data = '0; rt_data = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    cyc(0, 32'h0, 0, 0, 1);
    chk("bubble_first", 64'(bubble_cnt), 64'd1);
    cyc(0, 32'h0, 0, 0, 1);
    chk("bubble_second", 64'(bubble_cnt), 64'd2);

    // SLL load and sign extension
    in_valid = 1'b1; instr = 32'h0002_1100; rs_data = '0; rt_data = 32'h3;
    pc_plus4 = 32'h104; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    chk("sll_valid", 64'(out_valid), 64'd1);
    chk("sll_op_funct", 64'({inst31_26, inst5_0}), 64'd0);
    chk("sll_shamt", 64'(inst10_6), 64'd4);
    chk("sll_rt_rd", 64'({rt_idx, rd_idx}), 64'({5'd2, 5'd2}));
    chk("sll_datab", 64'(datab), 64'd3);
    cyc(1, 32'h2008_FFFC, 0, 0, 1);
    chk("sext_neg", 64'(imm_sext), 64'hFFFF_FFFC);
    cyc(1, 32'h2008_0010, 0, 0, 1);
    chk("sext_pos", 64'(imm_sext), 64'h0000_0010);
    cyc(0, 32'h0, 0, 0, 1);

    // Backpressure: A held while B waits, then B loads as A drains
    cyc(1, 32'h0123_4567, 0, 0, 0);
    a_pc = pc_plus4;
    repeat (3) begin
      cyc(1, 32'h89AB_CDEF, 0, 0, 0);
      chk("bp_hold_a", 64'(pc_plus4_q), 64'(a_pc));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    cyc(1, 32'h89AB_CDEF, 0, 0, 1);
    b_rs = rs_data;
    chk("bp_b_loaded", 64'(dataa), 64'(b_rs));
    repeat (2) begin
      cyc(1, 32'h1111_2222, 1, 0, 1);
      chk("stall_hold_b", 64'(dataa), 64'(b_rs));
    end

    // Flush drops both held and incoming, also when stalled
    cyc(1, 32'h3333_4444, 0, 1, 0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1, 32'h5555_6666, 0, 0, 0);
    cyc(1, 32'h7777_8888, 1, 1, 1);
    chk("flush_stall_valid", 64'(out_valid), 64'd0);

    // Saturation and back-to-back streaming
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
    do_reset();
    repeat (20) cyc(0, 32'h0, 0, 0, 0);
    chk("bubble_saturated", 64'(bubble_cnt), 64'd15);
    for (int i = 0; i < 10; i++) begin
      cyc(1, $urandom, 0, 0, 1);
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    chk("stream_bubble_unchanged", 64'(bubble_cnt), 64'd15);

    // Random traffic from a fresh counter
    cyc(0, 32'h0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 6) == 0,
          ($urandom % 10) == 0, ($urandom % 3) != 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
